axi_dbus_sram: RTL and testbench

Single-port-per-channel AXI4 slave memory that terminates the processor data bus (`dBus_*`) in the RISC-V validation environment. It accepts single-beat 32-bit reads and writes with 8-bit IDs and byte strobes, keeps the contents in a word-addressed register array, and returns OKAY or SLVERR responses. Read and write channels run concurrently. An optional LFSR-driven backpressure mode stresses the core's handshake logic.

---
 rtl/axi_dbus_sram_if.sv | 76 +++++++
 rtl/axi_dbus_sram.sv | 216 +++++++++++++++++++++
 tb/tb_axi_dbus_sram.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_dbus_sram_if.sv
// ---------------------------------------------------------------------------
// axi_dbus_sram_if
// Single-beat AXI4 bus bundle between the processor data-bus master and the
// axi_dbus_sram slave memory.
//   AW : s_awvalid/s_awready, s_awaddr, s_awid, s_awsize, s_awburst, s_awlen
//   W  : s_wvalid/s_wready, s_wdata, s_wstrb, s_wlast
//   B  : s_bvalid/s_bready, s_bid, s_bresp
//   AR : s_arvalid/s_arready, s_araddr, s_arid, s_arsize, s_arburst, s_arlen
//   R  : s_rvalid/s_rready, s_rdata, s_rid, s_rresp, s_rlast
// Handshake rule on every channel: a beat transfers on a rising clock edge
// where valid and ready are both 1; once valid is raised the sender holds
// valid and payload stable until that edge.
// ---------------------------------------------------------------------------
interface axi_dbus_sram_if #(
    parameter int ID_W = 8
);
    logic            s_awvalid;
    logic            s_awready;
    logic [31:0]     s_awaddr;
    logic [ID_W-1:0] s_awid;
    logic [2:0]      s_awsize;
    logic [1:0]      s_awburst;
    logic [7:0]      s_awlen;

    logic            s_wvalid;
    logic            s_wready;
    logic [31:0]     s_wdata;
    logic [3:0]      s_wstrb;
    logic            s_wlast;

    logic            s_bvalid;
    logic            s_bready;
    logic [ID_W-1:0] s_bid;
    logic [1:0]      s_bresp;

    logic            s_arvalid;
    logic            s_arready;
    logic [31:0]     s_araddr;
    logic [ID_W-1:0] s_arid;
    logic [2:0]      s_arsize;
    logic [1:0]      s_arburst;
    logic [7:0]      s_arlen;

    logic            s_rvalid;
    logic            s_rready;
    logic [31:0]     s_rdata;
    logic [ID_W-1:0] s_rid;
    logic [1:0]      s_rresp;
    logic            s_rlast;

    modport slave (
        input  s_awvalid, s_awaddr, s_awid, s_awsize, s_awburst, s_awlen,
        output s_awready,
        input  s_wvalid, s_wdata, s_wstrb, s_wlast,
        output s_wready,
        output s_bvalid, s_bid, s_bresp,
        input  s_bready,
        input  s_arvalid, s_araddr, s_arid, s_arsize, s_arburst, s_arlen,
        output s_arready,
        output s_rvalid, s_rdata, s_rid, s_rresp, s_rlast,
        input  s_rready
    );

    modport master (
        output s_awvalid, s_awaddr, s_awid, s_awsize, s_awburst, s_awlen,
        input  s_awready,
        output s_wvalid, s_wdata, s_wstrb, s_wlast,
        input  s_wready,
        input  s_bvalid, s_bid, s_bresp,
        output s_bready,
        output s_arvalid, s_araddr, s_arid, s_arsize, s_arburst, s_arlen,
        input  s_arready,
        input  s_rvalid, s_rdata, s_rid, s_rresp, s_rlast,
        output s_rready
    );
endinterface

// File: rtl/axi_dbus_sram.sv
// ---------------------------------------------------------------------------
// axi_dbus_sram
// AXI4 slave memory terminating the processor data bus. Single-beat 32-bit
// reads and writes with byte strobes; word-addressed register array; OKAY or
// SLVERR responses. Read and write sides run independently.
//   clk  : sole clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : axi_dbus_sram_if.slave (AW, W, B, AR, R channels)
// Optional feature macro: DBUS_SRAM_RAND_STALL_EN -- a 16-bit LFSR randomly
// deasserts the AW/W/AR ready outputs to stress the master.
// Debug: o_dbg_w_state / o_dbg_r_state expose the two FSM states.
// ---------------------------------------------------------------------------
module axi_dbus_sram #(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          ID_W        = 8,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    axi_dbus_sram_if.slave     bus,
    output logic               o_dbg_w_state,
    output logic               o_dbg_r_state
);
    localparam int          IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN_BYTES = 33'(4 * DEPTH_WORDS);

    typedef enum logic { W_IDLE = 1'b0, W_RESP = 1'b1 } w_state_t;
    typedef enum logic { R_IDLE = 1'b0, R_RESP = 1'b1 } r_state_t;

    // Address window and word alignment; offset compared in 33 bits so the
    // window end never wraps.
    function automatic logic addr_ok(input logic [31:0] a);
        logic [31:0] off;
        off = a - ADDR_BASE;
        return (a >= ADDR_BASE) && ({1'b0, off} < SPAN_BYTES) && (a[1:0] == 2'b00);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] a);
        logic [31:0] off;
        off = a - ADDR_BASE;
        return off[IDX_W+1:2];
    endfunction

    logic [31:0] r_mem [DEPTH_WORDS];

    // ------------------------------------------------------------------ stall
    logic w_stall;
`ifdef DBUS_SRAM_RAND_STALL_EN
    logic [15:0] r_lfsr;
    logic        w_lfsr_fb;
    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    always_ff @(posedge clk) begin
        if (rst) r_lfsr <= LFSR_SEED;
        else     r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
    end
    assign w_stall = r_lfsr[0];
`else
    assign w_stall = 1'b0;
`endif

    // ------------------------------------------------------------ write side
    w_state_t        r_w_state, w_w_state_nxt;
    logic            r_aw_full, r_aw_ok, r_w_full, r_w_last;
    logic [IDX_W-1:0] r_aw_idx;
    logic [ID_W-1:0] r_aw_id, r_bid;
    logic [31:0]     r_w_data;
    logic [3:0]      r_w_strb;
    logic [1:0]      r_bresp;
    logic            w_awready, w_wready, w_bvalid;
    logic            w_aw_hs, w_w_hs, w_commit, w_wr_legal;

    assign w_aw_hs    = bus.s_awvalid & w_awready;
    assign w_w_hs     = bus.s_wvalid & w_wready;
    assign w_commit   = (r_w_state == W_IDLE) & r_aw_full & r_w_full & ~rst;
    assign w_wr_legal = r_aw_ok & r_w_last;

    always_ff @(posedge clk) begin
        if (rst) r_w_state <= W_IDLE;
        else     r_w_state <= w_w_state_nxt;
    end

    always_comb begin
        w_w_state_nxt = r_w_state;
        case (r_w_state)
            W_IDLE:  if (w_commit)     w_w_state_nxt = W_RESP;
            W_RESP:  if (bus.s_bready) w_w_state_nxt = W_IDLE;
            default: w_w_state_nxt = W_IDLE;
        endcase
    end

    // Readies depend only on registered state (plus reset/stall), never on valids.
    always_comb begin
        w_awready = 1'b0;
        w_wready  = 1'b0;
        w_bvalid  = 1'b0;
        if (!rst) begin
            w_awready = (r_w_state == W_IDLE) & ~r_aw_full & ~w_stall;
            w_wready  = (r_w_state == W_IDLE) & ~r_w_full & ~w_stall;
            w_bvalid  = (r_w_state == W_RESP);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_aw_full <= 1'b0;
            r_aw_ok   <= 1'b0;
            r_aw_idx  <= '0;
            r_aw_id   <= '0;
            r_w_full  <= 1'b0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
            r_w_last  <= 1'b0;
            r_bid     <= '0;
            r_bresp   <= 2'b00;
        end else begin
            if (w_aw_hs) begin
                r_aw_full <= 1'b1;
                r_aw_ok   <= addr_ok(bus.s_awaddr) && (bus.s_awsize == 3'b010) &&
                             (bus.s_awburst == 2'b01) && (bus.s_awlen == 8'd0);
                r_aw_idx  <= addr_idx(bus.s_awaddr);
                r_aw_id   <= bus.s_awid;
            end
            if (w_w_hs) begin
                r_w_full <= 1'b1;
                r_w_data <= bus.s_wdata;
                r_w_strb <= bus.s_wstrb;
                r_w_last <= bus.s_wlast;
            end
            if (w_commit) begin
                r_aw_full <= 1'b0;
                r_w_full  <= 1'b0;
                r_bid     <= r_aw_id;
                r_bresp   <= w_wr_legal ? 2'b00 : 2'b10;
            end
        end
    end

    // Memory contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_commit && w_wr_legal) begin
            for (int i = 0; i < 4; i++) begin
                if (r_w_strb[i]) r_mem[r_aw_idx][8*i +: 8] <= r_w_data[8*i +: 8];
            end
        end
    end

    // ------------------------------------------------------------- read side
    r_state_t        r_r_state, w_r_state_nxt;
    logic [31:0]     r_rdata;
    logic [ID_W-1:0] r_rid;
    logic [1:0]      r_rresp;
    logic            r_rlast;
    logic            w_arready, w_rvalid, w_ar_hs, w_ar_legal;

    assign w_ar_hs    = bus.s_arvalid & w_arready;
    assign w_ar_legal = addr_ok(bus.s_araddr) && (bus.s_arsize == 3'b010) &&
                        (bus.s_arburst == 2'b01) && (bus.s_arlen == 8'd0);

    always_ff @(posedge clk) begin
        if (rst) r_r_state <= R_IDLE;
        else     r_r_state <= w_r_state_nxt;
    end

    always_comb begin
        w_r_state_nxt = r_r_state;
        case (r_r_state)
            R_IDLE:  if (w_ar_hs)      w_r_state_nxt = R_RESP;
            R_RESP:  if (bus.s_rready) w_r_state_nxt = R_IDLE;
            default: w_r_state_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        w_arready = 1'b0;
        w_rvalid  = 1'b0;
        if (!rst) begin
            w_arready = (r_r_state == R_IDLE) & ~w_stall;
            w_rvalid  = (r_r_state == R_RESP);
        end
    end

    // Array read uses pre-edge contents, so a same-cycle write commit is not seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
            r_rid   <= '0;
            r_rresp <= 2'b00;
            r_rlast <= 1'b0;
        end else if (w_ar_hs) begin
            r_rdata <= w_ar_legal ? r_mem[addr_idx(bus.s_araddr)] : 32'h0;
            r_rid   <= bus.s_arid;
            r_rresp <= w_ar_legal ? 2'b00 : 2'b10;
            r_rlast <= 1'b1;
        end else if (w_rvalid && bus.s_rready) begin
            r_rlast <= 1'b0;
        end
    end

    // ---------------------------------------------------------------- outputs
    // Payloads are forced to zero while reset is asserted.
    assign bus.s_awready = w_awready;
    assign bus.s_wready  = w_wready;
    assign bus.s_bvalid  = w_bvalid;
    assign bus.s_bid     = rst ? '0 : r_bid;
    assign bus.s_bresp   = rst ? 2'b00 : r_bresp;
    assign bus.s_arready = w_arready;
    assign bus.s_rvalid  = w_rvalid;
    assign bus.s_rdata   = rst ? 32'h0 : r_rdata;
    assign bus.s_rid     = rst ? '0 : r_rid;
    assign bus.s_rresp   = rst ? 2'b00 : r_rresp;
    assign bus.s_rlast   = rst ? 1'b0 : r_rlast;

    assign o_dbg_w_state = r_w_state;
    assign o_dbg_r_state = r_r_state;
endmodule

// File: tb/tb_axi_dbus_sram.sv
// ---------------------------------------------------------------------------
// tb_axi_dbus_sram
// Directed table of single-beat reads/writes with hand-computed responses,
// hand-written timing/corner sequences, and a random data phase checked
// against a small word model through an expected queue.
// ---------------------------------------------------------------------------
module tb_axi_dbus_sram;
    logic clk = 1'b0;
    logic rst;
    logic dbg_w_state, dbg_r_state;

    always #5 clk = ~clk;

    axi_dbus_sram_if #(.ID_W(8)) bus ();

    axi_dbus_sram dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus.slave),
        .o_dbg_w_state (dbg_w_state),
        .o_dbg_r_state (dbg_r_state)
    );

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [7:0]  id;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [7:0]  len;
        bit          last;
        logic [1:0]  exp_resp;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    // ------------------------------------------------------------- checking
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [57:0] all_outputs();
        return {bus.s_awready, bus.s_wready, bus.s_arready, bus.s_bvalid, bus.s_rvalid,
                bus.s_rlast, bus.s_rresp, bus.s_bresp, bus.s_rid, bus.s_bid, bus.s_rdata};
    endfunction

    // -------------------------------------------------------------- drivers
    task automatic idle_inputs();
        bus.s_awvalid = 0; bus.s_awaddr = 0; bus.s_awid = 0; bus.s_awsize = 0;
        bus.s_awburst = 0; bus.s_awlen = 0;
        bus.s_wvalid = 0; bus.s_wdata = 0; bus.s_wstrb = 0; bus.s_wlast = 0;
        bus.s_bready = 1;
        bus.s_arvalid = 0; bus.s_araddr = 0; bus.s_arid = 0; bus.s_arsize = 0;
        bus.s_arburst = 0; bus.s_arlen = 0;
        bus.s_rready = 1;
    endtask

    task automatic send_aw(input logic [31:0] addr, input logic [7:0] id, input logic [2:0] size,
                           input logic [1:0] burst, input logic [7:0] len);
        int n = 0;
        bus.s_awvalid = 1; bus.s_awaddr = addr; bus.s_awid = id;
        bus.s_awsize = size; bus.s_awburst = burst; bus.s_awlen = len;
        @(negedge clk);
        while (!bus.s_awready && n < 200) begin @(negedge clk); n++; end
        check("aw_handshake", bus.s_awready, 1);
        @(posedge clk); #1;
        bus.s_awvalid = 0;
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int n = 0;
        bus.s_wvalid = 1; bus.s_wdata = data; bus.s_wstrb = strb; bus.s_wlast = last;
        @(negedge clk);
        while (!bus.s_wready && n < 200) begin @(negedge clk); n++; end
        check("w_handshake", bus.s_wready, 1);
        @(posedge clk); #1;
        bus.s_wvalid = 0;
    endtask

    task automatic send_ar(input logic [31:0] addr, input logic [7:0] id, input logic [2:0] size,
                           input logic [1:0] burst, input logic [7:0] len);
        int n = 0;
        bus.s_arvalid = 1; bus.s_araddr = addr; bus.s_arid = id;
        bus.s_arsize = size; bus.s_arburst = burst; bus.s_arlen = len;
        @(negedge clk);
        while (!bus.s_arready && n < 200) begin @(negedge clk); n++; end
        check("ar_handshake", bus.s_arready, 1);
        @(posedge clk); #1;
        bus.s_arvalid = 0;
    endtask

    // Leaves the bench at a negedge with bvalid seen (or timed out).
    task automatic wait_bvalid();
        int n = 0;
        @(negedge clk);
        while (!bus.s_bvalid && n < 200) begin @(negedge clk); n++; end
        check("b_arrives", bus.s_bvalid, 1);
    endtask

    task automatic wait_rvalid();
        int n = 0;
        @(negedge clk);
        while (!bus.s_rvalid && n < 200) begin @(negedge clk); n++; end
        check("r_arrives", bus.s_rvalid, 1);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] id, input logic [31:0] data,
                            input logic [3:0] strb, input logic [2:0] size, input logic [1:0] burst,
                            input logic [7:0] len, input logic last,
                            output logic [7:0] bid, output logic [1:0] bresp);
        fork
            send_aw(addr, id, size, burst, len);
            send_w(data, strb, last);
        join
        wait_bvalid();
        bid = bus.s_bid;
        bresp = bus.s_bresp;
        @(posedge clk); #1;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] id, input logic [2:0] size,
                           input logic [1:0] burst, input logic [7:0] len,
                           output logic [31:0] data, output logic [1:0] resp,
                           output logic [7:0] rid, output logic rlast);
        send_ar(addr, id, size, burst, len);
        wait_rvalid();
        data = bus.s_rdata;
        resp = bus.s_rresp;
        rid = bus.s_rid;
        rlast = bus.s_rlast;
        @(posedge clk); #1;
    endtask

    function automatic vec_t mk(input bit is_wr, input logic [31:0] addr, input logic [7:0] id,
                                input logic [31:0] data, input logic [3:0] strb, input logic [2:0] size,
                                input logic [1:0] burst, input logic [7:0] len, input bit last,
                                input logic [1:0] exp_resp, input logic [31:0] exp_data);
        vec_t v;
        v.is_wr = is_wr; v.addr = addr; v.id = id; v.data = data; v.strb = strb;
        v.size = size; v.burst = burst; v.len = len; v.last = last;
        v.exp_resp = exp_resp; v.exp_data = exp_data;
        return v;
    endfunction

    // ------------------------------------------------------------- stimulus
    initial begin
        logic [7:0]  bid, rid;
        logic [1:0]  bresp, rresp;
        logic [31:0] rdata;
        logic        rlast;
        logic [31:0] model [16];
        int          n_rand;

        // Directed table; entries run in order and depend on earlier writes.
        vecs.push_back(mk(1, 32'h8000_0020, 8'h01, 32'hCAFE_F00D, 4'hF, 3'd2, 2'd1, 8'd0, 1, 2'b00, 32'h0));
        vecs.push_back(mk(0, 32'h8000_0020, 8'h02, 32'h0,         4'h0, 3'd2, 2'd1, 8'd0, 1, 2'b00, 32'hCAFE_F00D));
        vecs.push_back(mk(1, 32'h8000_0020, 8'h03, 32'h1100_0000, 4'h8, 3'd2, 2'd1, 8'd0, 1, 2'b00, 32'h0));
        vecs.push_back(mk(0, 32'h8000_0020, 8'h04, 32'h0,         4'h0, 3'd2, 2'd1, 8'd0, 1, 2'b00, 32'h11FE_F00D));
        vecs.push_back(mk(0, 32'h7FFF_FFFC, 8'h05, 32'h0,         4'h0, 3'd2, 2'd1, 8'd0, 1, 2'b10, 32'h0));
        vecs.push_back(mk(0, 32'h8000_0002, 8'h06, 32'h0,         4'h0, 3'd2, 2'd1, 8'd0, 1, 2'b10, 32'h0));
        vecs.push_back(mk(1, 32'h8000_0020, 8'h07, 32'hFFFF_FFFF, 4'hF, 3'd2, 2'd1, 8'd1, 1, 2'b10, 32'h0));
        vecs.push_back(mk(0, 32'h8000_0020, 8'h08, 32'h0,         4'h0, 3'd2, 2'd1, 8'd0, 1, 2'b00, 32'h11FE_F00D));
        vecs.push_back(mk(1, 32'h8000_4000, 8'h09, 32'hFFFF_FFFF, 4'hF, 3'd2, 2'd1, 8'd0, 1, 2'b10, 32'h0));
        vecs.push_back(mk(1, 32'h8000_3FFC, 8'h0A, 32'h0BAD_F00D, 4'hF, 3'd2, 2'd1, 8'd0, 1, 2'b00, 32'h0));
        vecs.push_back(mk(0, 32'h8000_3FFC, 8'h0B, 32'h0,         4'h0, 3'd2, 2'd1, 8'd0, 1, 2'b00, 32'h0BAD_F00D));
        vecs.push_back(mk(0, 32'h8000_4000, 8'h0C, 32'h0,         4'h0, 3'd2, 2'd1, 8'd0, 1, 2'b10, 32'h0));
        vecs.push_back(mk(0, 32'h8000_3FFC, 8'h0D, 32'h0,         4'h0, 3'd3, 2'd1, 8'd0, 1, 2'b10, 32'h0));
        vecs.push_back(mk(0, 32'h8000_3FFC, 8'h0E, 32'h0,         4'h0, 3'd2, 2'd0, 8'd0, 1, 2'b10, 32'h0));
        vecs.push_back(mk(1, 32'h8000_3FFC, 8'h0F, 32'h1234_5678, 4'hF, 3'd2, 2'd1, 8'd0, 0, 2'b10, 32'h0));
        vecs.push_back(mk(1, 32'h8000_3FFC, 8'h10, 32'h1234_5678, 4'hF, 3'd1, 2'd1, 8'd0, 1, 2'b10, 32'h0));
        vecs.push_back(mk(1, 32'h8000_3FFE, 8'h12, 32'h1234_5678, 4'hF, 3'd2, 2'd1, 8'd0, 1, 2'b10, 32'h0));
        vecs.push_back(mk(0, 32'h8000_3FFC, 8'h13, 32'h0,         4'h0, 3'd2, 2'd1, 8'd0, 1, 2'b00, 32'h0BAD_F00D));

        // ---- reset: every output low while rst is high
        idle_inputs();
        rst = 1;
        @(posedge clk); #1;
        @(negedge clk); check("reset_outputs_a", all_outputs(), 58'h0);
        @(negedge clk); check("reset_outputs_b", all_outputs(), 58'h0);
        @(posedge clk); #1;
        rst = 0;
`ifndef DBUS_SRAM_RAND_STALL_EN
        @(negedge clk);
        check("ready_after_reset", {bus.s_awready, bus.s_wready, bus.s_arready}, 3'b111);
        @(posedge clk); #1;

        // ---- write/read latency: AW+W at T, bvalid at T+2; AR at T, rvalid at T+1
        bus.s_awvalid = 1; bus.s_awaddr = 32'h8000_0010; bus.s_awid = 8'h5A;
        bus.s_awsize = 3'd2; bus.s_awburst = 2'd1; bus.s_awlen = 8'd0;
        bus.s_wvalid = 1; bus.s_wdata = 32'hDEAD_BEEF; bus.s_wstrb = 4'hF; bus.s_wlast = 1;
        @(negedge clk); check("lat_ready_t", {bus.s_awready, bus.s_wready}, 2'b11);
        @(posedge clk); #1;
        bus.s_awvalid = 0; bus.s_wvalid = 0;
        @(negedge clk); check("lat_bvalid_t1", bus.s_bvalid, 0);
        @(negedge clk); check("lat_bvalid_t2", bus.s_bvalid, 1);
        check("lat_bid", bus.s_bid, 8'h5A);
        check("lat_bresp", bus.s_bresp, 2'b00);
        @(posedge clk); #1;
        bus.s_arvalid = 1; bus.s_araddr = 32'h8000_0010; bus.s_arid = 8'h33;
        bus.s_arsize = 3'd2; bus.s_arburst = 2'd1; bus.s_arlen = 8'd0;
        @(negedge clk); check("lat_arready", bus.s_arready, 1);
        @(posedge clk); #1;
        bus.s_arvalid = 0;
        @(negedge clk);
        check("lat_rvalid_t1", bus.s_rvalid, 1);
        check("lat_rdata", bus.s_rdata, 32'hDEAD_BEEF);
        check("lat_rid", bus.s_rid, 8'h33);
        check("lat_rresp", bus.s_rresp, 2'b00);
        check("lat_rlast", bus.s_rlast, 1);
        @(posedge clk); #1;
`else
        do_write(32'h8000_0010, 8'h5A, 32'hDEAD_BEEF, 4'hF, 3'd2, 2'd1, 8'd0, 1, bid, bresp);
        check("first_bid", bid, 8'h5A);
        check("first_bresp", bresp, 2'b00);
        do_read(32'h8000_0010, 8'h33, 3'd2, 2'd1, 8'd0, rdata, rresp, rid, rlast);
        check("first_rdata", rdata, 32'hDEAD_BEEF);
        check("first_rid", rid, 8'h33);
        check("first_rresp", rresp, 2'b00);
        check("first_rlast", rlast, 1);
`endif

        // ---- W two cycles ahead of AW, partial strobe merge
        send_w(32'h1122_3344, 4'b0101, 1);
        @(posedge clk); #1;
`ifndef DBUS_SRAM_RAND_STALL_EN
        @(negedge clk);
        check("w_held_ready", {bus.s_awready, bus.s_wready, bus.s_bvalid}, 3'b100);
`endif
        @(posedge clk); #1;
        send_aw(32'h8000_0010, 8'h21, 3'd2, 2'd1, 8'd0);
        wait_bvalid();
        check("early_w_bid", bus.s_bid, 8'h21);
        check("early_w_bresp", bus.s_bresp, 2'b00);
        @(posedge clk); #1;
        do_read(32'h8000_0010, 8'h22, 3'd2, 2'd1, 8'd0, rdata, rresp, rid, rlast);
        check("strobe_merge", rdata, 32'hDE22_BE44);

        // ---- directed table
        foreach (vecs[i]) begin
            if (vecs[i].is_wr) begin
                do_write(vecs[i].addr, vecs[i].id, vecs[i].data, vecs[i].strb, vecs[i].size,
                         vecs[i].burst, vecs[i].len, vecs[i].last, bid, bresp);
                check($sformatf("vec%0d_bid", i), bid, vecs[i].id);
                check($sformatf("vec%0d_bresp", i), bresp, vecs[i].exp_resp);
            end else begin
                do_read(vecs[i].addr, vecs[i].id, vecs[i].size, vecs[i].burst, vecs[i].len,
                        rdata, rresp, rid, rlast);
                check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_data);
                check($sformatf("vec%0d_rresp", i), rresp, vecs[i].exp_resp);
                check($sformatf("vec%0d_rid", i), rid, vecs[i].id);
                check($sformatf("vec%0d_rlast", i), rlast, 1);
            end
        end

        // ---- response backpressure: B and R held 5 cycles, request readies low
        bus.s_bready = 0;
        fork
            send_aw(32'h8000_0030, 8'h44, 3'd2, 2'd1, 8'd0);
            send_w(32'h5555_AAAA, 4'hF, 1);
        join
        wait_bvalid();
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bhold%0d_bvalid", c), bus.s_bvalid, 1);
            check($sformatf("bhold%0d_bid", c), bus.s_bid, 8'h44);
            check($sformatf("bhold%0d_bresp", c), bus.s_bresp, 2'b00);
            check($sformatf("bhold%0d_readies", c), {bus.s_awready, bus.s_wready}, 2'b00);
            @(negedge clk);
        end
        bus.s_bready = 1;
        @(posedge clk); #1;
        bus.s_rready = 0;
        send_ar(32'h8000_0030, 8'h45, 3'd2, 2'd1, 8'd0);
        wait_rvalid();
        for (int c = 0; c < 5; c++) begin
            check($sformatf("rhold%0d_rvalid", c), bus.s_rvalid, 1);
            check($sformatf("rhold%0d_rdata", c), bus.s_rdata, 32'h5555_AAAA);
            check($sformatf("rhold%0d_rid", c), bus.s_rid, 8'h45);
            check($sformatf("rhold%0d_rlast", c), bus.s_rlast, 1);
            check($sformatf("rhold%0d_arready", c), bus.s_arready, 0);
            @(negedge clk);
        end
        bus.s_rready = 1;
        @(posedge clk); #1;

`ifndef DBUS_SRAM_RAND_STALL_EN
        // ---- read and write commit in the same cycle at one address
        do_write(32'h8000_0040, 8'h50, 32'h0, 4'hF, 3'd2, 2'd1, 8'd0, 1, bid, bresp);
        bus.s_awvalid = 1; bus.s_awaddr = 32'h8000_0040; bus.s_awid = 8'h51;
        bus.s_awsize = 3'd2; bus.s_awburst = 2'd1; bus.s_awlen = 8'd0;
        bus.s_wvalid = 1; bus.s_wdata = 32'h1; bus.s_wstrb = 4'hF; bus.s_wlast = 1;
        @(posedge clk); #1;
        bus.s_awvalid = 0; bus.s_wvalid = 0;
        bus.s_arvalid = 1; bus.s_araddr = 32'h8000_0040; bus.s_arid = 8'h52;
        bus.s_arsize = 3'd2; bus.s_arburst = 2'd1; bus.s_arlen = 8'd0;
        @(posedge clk); #1;
        bus.s_arvalid = 0;
        @(negedge clk);
        check("collide_rvalid", bus.s_rvalid, 1);
        check("collide_old_data", bus.s_rdata, 32'h0);
        check("collide_bvalid", bus.s_bvalid, 1);
        @(posedge clk); #1;
        do_read(32'h8000_0040, 8'h53, 3'd2, 2'd1, 8'd0, rdata, rresp, rid, rlast);
        check("collide_new_data", rdata, 32'h1);
`endif

        // ---- reset one cycle after an AR handshake drops the read
        send_ar(32'h8000_0010, 8'h60, 3'd2, 2'd1, 8'd0);
        rst = 1;
        @(negedge clk); check("midrst_outputs_a", all_outputs(), 58'h0);
        @(negedge clk); check("midrst_outputs_b", all_outputs(), 58'h0);
        @(posedge clk); #1;
        rst = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("midrst_no_rvalid%0d", c), bus.s_rvalid, 0);
        end
        @(posedge clk); #1;
        do_read(32'h8000_0010, 8'h61, 3'd2, 2'd1, 8'd0, rdata, rresp, rid, rlast);
        check("post_rst_rdata", rdata, 32'hDE22_BE44);
        check("post_rst_rid", rid, 8'h61);

        // ---- random data phase against a 16-word model
`ifdef DBUS_SRAM_RAND_STALL_EN
        n_rand = 1000;
`else
        n_rand = 200;
`endif
        for (int k = 0; k < 16; k++) begin
            model[k] = $urandom;
            do_write(32'h8000_0100 + 32'(k * 4), 8'(k), model[k], 4'hF, 3'd2, 2'd1, 8'd0, 1, bid, bresp);
            check("seed_bresp", bresp, 2'b00);
        end
        for (int t = 0; t < n_rand; t++) begin
            int          idx;
            logic [7:0]  id;
            logic [31:0] d;
            logic [3:0]  s;
            idx = $urandom_range(0, 15);
            id  = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                for (int b = 0; b < 4; b++) if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
                do_write(32'h8000_0100 + 32'(idx * 4), id, d, s, 3'd2, 2'd1, 8'd0, 1, bid, bresp);
                check("rand_bid", bid, id);
                check("rand_bresp", bresp, 2'b00);
            end else begin
                exp_q.push_back(model[idx]);
                do_read(32'h8000_0100 + 32'(idx * 4), id, 3'd2, 2'd1, 8'd0, rdata, rresp, rid, rlast);
                check("rand_rdata", rdata, exp_q.pop_front());
                check("rand_rid", rid, id);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end
endmodule
